ripple_adder_seq: RTL and testbench
===================================

# ripple_adder_seq

Multi-cycle adder/subtractor controller that computes wide sums by time-sharing a single 4-bit `ripple_adder` instance, one nibble per clock, least significant nibble first. It sits between an operand producer and a result consumer. Both sides use valid/ready handshakes. The block owns the carry chain between nibbles and sequences the shared adder with a three-state FSM.

## Interface
- `NIBBLES`, default 4: operand width in 4-bit nibbles. Legal range is 1..16. Data width is W = 4*NIBBLES.
- `clk` input, 1 bit: the only clock. All state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in_valid` input, 1 bit: operand beat valid.
- `in_ready` output, 1 bit: block can accept an operand beat.
- `a` input, W bits: operand A, unsigned.
- `b` input, W bits: operand B, unsigned.
- `cin` input, 1 bit: carry-in. Ignored when `sub`=1.
- `sub` input, 1 bit: 0 computes A+B+cin; 1 computes A-B.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `sum` output, W bits: result, modulo 2^W.
- `cout` output, 1 bit: final carry. When `sub`=1, it is the no-borrow flag (1 means A>=B).

## Operation
- Instantiates exactly one `ripple_adder` with ports (A[3:0], B[3:0], Cin, Sum[3:0], Cout). No other adder logic is allowed on the datapath.
- Registers:
  - `a_r`, `b_r`: W bits each.
  - `c_r`: 1 bit.
  - `idx`: counter, ceil(log2(NIBBLES)) bits, minimum 1 bit.
  - `sum_r`: W bits.
  - `cout_r`: 1 bit.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid`=1, the operand is accepted and the following registers load:
    - `a_r`<=a.
    - `b_r`<=(sub ? ~b : b).
    - `c_r`<=(sub ? 1 : cin).
    - `idx`<=0.
  - The FSM then moves to RUN.
- RUN:
  - `in_ready`=0 and `out_valid`=0.
  - The adder is driven with `a_r` nibble `idx`, `b_r` nibble `idx`, and `c_r`.
  - Each edge, `sum_r` nibble `idx`<=adder Sum and `c_r`<=adder Cout.
  - If `idx`==NIBBLES-1: `cout_r`<=adder Cout and the FSM moves to DONE. Otherwise `idx`<=idx+1.
- DONE:
  - `out_valid`=1 and `in_ready`=0.
  - `sum`/`cout` hold stable until the result is accepted.
  - When `out_ready`=1, the result is consumed and the FSM returns to IDLE.
- `in_ready` and `out_valid` are decoded from the state only. They do not combinationally depend on `in_valid` or `out_ready`.
- `sum`=`sum_r` and `cout`=`cout_r` at all times. Values persist in IDLE until RUN overwrites them nibble by nibble.
- Inputs `a`, `b`, `cin` and `sub` are sampled only in the accept cycle. Later changes have no effect.
- `in_valid` asserted outside IDLE is ignored. No operand is queued.
- `out_ready` outside DONE is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready`=1 and `out_valid`=0.
  - `sum`=0 and `cout`=0.
  - `idx`=0, `c_r`=0, `a_r`=0 and `b_r`=0.
- Latency: the accept happens on edge E. RUN occupies edges E+1..E+NIBBLES. `out_valid` rises after edge E+NIBBLES.
- With `out_ready` held high, throughput is one operation per NIBBLES+2 cycles.
- There is no overlap: `in_ready` returns to 1 only in the cycle after the DONE handshake.
- NIBBLES=1: RUN lasts one cycle and the FSM moves directly to DONE.
- Back-pressure: DONE persists indefinitely while `out_ready`=0, with `sum`/`cout` unchanged.
- Reset asserted in any state, including mid-RUN or mid-DONE: on that edge everything returns to reset values and the operation is discarded. No `out_valid` pulse is produced.
- Simultaneous `rst` and `in_valid`: reset wins and no accept occurs.
- Wrap-around: the result is modulo 2^W. Overflow is reported only via `cout`.

## Test plan
- Reset: assert `rst` 2 cycles, then release. Check `in_ready`=1, `out_valid`=0, `sum`=0 and `cout`=0.
- Basic add (NIBBLES=4): a=0x1234, b=0x4321, cin=0, sub=0, `out_ready`=1. Expect `out_valid` after exactly 4 edges past accept, `sum`=0x5555, `cout`=0, one-cycle `out_valid` pulse, then `in_ready`=1.
- Carry chain and wrap:
  - 0x0FFF+0x0001 gives `sum`=0x1000, `cout`=0.
  - 0xFFFF+0x0001 gives `sum`=0x0000, `cout`=1.
  - 0xFFFF+0xFFFF with cin=1 gives `sum`=0xFFFF, `cout`=1.
- Subtract:
  - 0x0005-0x0007 gives `sum`=0xFFFE, `cout`=0.
  - 0x0007-0x0005 gives `sum`=0x0002, `cout`=1.
  - Confirm `cin` is ignored by driving cin=1 in both cases.
- Back-pressure and ignored inputs: hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid`/`a`/`b`. Check `sum`/`cout` are stable and `in_ready`=0. Then raise `out_ready`: exactly one result is consumed and the next accept occurs only after returning to IDLE.
- Reset mid-operation: accept 0x1234+0x4321, then assert `rst` on the 2nd RUN cycle. Expect no `out_valid`, `sum`=0 and IDLE on the next cycle. A following op 0x0001+0x0001 gives `sum`=0x0002. Repeat the directed add with NIBBLES=1: 0xF+0x1 gives `sum`=0x0, `cout`=1, latency 1.

Source files
------------

// File: rtl/ripple_adder_seq.sv
// Multi-cycle adder/subtractor that time-shares one 4-bit ripple adder,
// processing one nibble per clock, least significant nibble first.

module ripple_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] w_carry;

  assign w_carry[0] = Cin;

  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign Sum[g]       = A[g] ^ B[g] ^ w_carry[g];
    assign w_carry[g+1] = (A[g] & B[g]) | (w_carry[g] & (A[g] ^ B[g]));
  end

  assign Cout = w_carry[4];

endmodule

module ripple_adder_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_c;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_sum;
  logic          r_cout;

  logic [3:0] w_aNib;
  logic [3:0] w_bNib;
  logic [3:0] w_sumNib;
  logic       w_coutNib;
  logic       w_lastNib;

  assign w_aNib    = r_a[r_idx*4 +: 4];
  assign w_bNib    = r_b[r_idx*4 +: 4];
  assign w_lastNib = (r_idx == IDX_LAST);

  ripple_adder u_adder (
    .A   (w_aNib),
    .B   (w_bNib),
    .Cin (r_c),
    .Sum (w_sumNib),
    .Cout(w_coutNib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Handshake outputs depend on state alone so neither side sees a combinational path.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_nextState = RUN;
      end
      RUN: begin
        if (w_lastNib) w_nextState = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the operand inversion and forced carry happen at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_idx  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= sub ? ~b : b;
            r_c   <= sub ? 1'b1 : cin;
            r_idx <= '0;
          end
        end
        RUN: begin
          r_sum[r_idx*4 +: 4] <= w_sumNib;
          r_c                 <= w_coutNib;
          if (w_lastNib) begin
            r_cout <= w_coutNib;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_ripple_adder_seq.sv
// Self-checking bench for ripple_adder_seq: directed table, random ops against
// an arithmetic reference model, back-pressure, reset and single-nibble cases.

module tb_ripple_adder_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout;

  logic       in_valid1, in_ready1, out_valid1, out_ready1;
  logic [3:0] a1, b1, sum1;
  logic       cin1, sub1, cout1;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  ripple_adder_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  ripple_adder_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] expSum;
    logic        expCout;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, cout is the carry out of bit 15 or the no-borrow flag
  function automatic logic [16:0] refModel(input logic [15:0] ra, input logic [15:0] rb,
                                            input logic rcin, input logic rsub);
    logic [16:0] full;
    if (rsub) begin
      full[15:0] = ra - rb;
      full[16]   = (ra >= rb);
    end else begin
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rcin};
    end
    return full;
  endfunction

  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb_,
                               input logic tcin, input logic tsub, input int hold,
                               output logic [15:0] gSum, output logic gCout, output int lat);
    int n;
    logic [15:0] heldSum;
    logic        heldCout;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready before accept", in_ready, 1);
    a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    checkOutput("in_ready during RUN", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    heldSum  = sum;
    heldCout = cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      checkOutput("backpressure sum stable", sum, heldSum);
      checkOutput("backpressure cout stable", cout, heldCout);
      checkOutput("backpressure out_valid", out_valid, 1);
      checkOutput("backpressure in_ready", in_ready, 0);
    end
    in_valid = (hold > 0);
    gSum  = sum;
    gCout = cout;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("out_valid single pulse", out_valid, 0);
    checkOutput("in_ready after handshake", in_ready, 1);
    checkOutput("sum held in idle", sum, gSum);
  endtask

  initial begin
    logic [15:0] gSum;
    logic        gCout;
    int          lat;
    logic [16:0] exp;
    logic [15:0] ra, rb;
    logic        rcin, rsub;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0};
    vecs[5] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset sum", sum, 0);
    checkOutput("reset cout", cout, 0);
    checkOutput("reset in_ready n1", in_ready1, 1);
    checkOutput("reset sum n1", sum1, 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0, gSum, gCout, lat);
      checkOutput($sformatf("vec%0d latency", i), lat, 4);
      checkOutput($sformatf("vec%0d sum", i), gSum, vecs[i].expSum);
      checkOutput($sformatf("vec%0d cout", i), gCout, vecs[i].expCout);
    end

    // Back-pressure with inputs toggling while DONE waits
    applyStimulus(16'hABCD, 16'h1111, 1'b0, 1'b0, 5, gSum, gCout, lat);
    checkOutput("bp sum", gSum, 16'hBCDE);
    checkOutput("bp cout", gCout, 0);
    applyStimulus(16'h0100, 16'h0022, 1'b0, 1'b0, 0, gSum, gCout, lat);
    checkOutput("after bp sum", gSum, 16'h0122);

    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rcin = 1'($urandom); rsub = 1'($urandom);
      exp = refModel(ra, rb, rcin, rsub);
      applyStimulus(ra, rb, rcin, rsub, int'($urandom_range(0, 2)), gSum, gCout, lat);
      checkOutput($sformatf("rand%0d latency", i), lat, 4);
      checkOutput($sformatf("rand%0d sum", i), gSum, exp[15:0]);
      checkOutput($sformatf("rand%0d cout", i), gCout, exp[16]);
    end

    // Reset on the second RUN edge discards the operation
    a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun rst in_ready", in_ready, 1);
    checkOutput("midrun rst out_valid", out_valid, 0);
    checkOutput("midrun rst sum", sum, 0);
    checkOutput("midrun rst cout", cout, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("midrun no out_valid", out_valid, 0);
    end
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 0, gSum, gCout, lat);
    checkOutput("post reset sum", gSum, 16'h0002);

    // Reset together with in_valid: no accept
    a = 16'h0003; b = 16'h0004; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("rst beats in_valid", in_ready, 1);

    // Single-nibble instance
    a1 = 4'hF; b1 = 4'h1; cin1 = 1'b0; sub1 = 1'b0; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("n1 latency", lat, 1);
    checkOutput("n1 sum", sum1, 4'h0);
    checkOutput("n1 cout", cout1, 1);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    checkOutput("n1 out_valid drop", out_valid1, 0);
    checkOutput("n1 in_ready back", in_ready1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
